// File: rtl/two_to_n_dispatch_pkg.sv
// vc_dispatch_pkg: lane count, default sizing and shared types for the 2-to-N
// response dispatcher and the users of the N-to-2 request arbiter.
package vc_dispatch_pkg;

  localparam int DISP_LANES     = 2;
  localparam int DISP_N         = 10;
  localparam int DISP_PLD_WIDTH = 8;
  localparam int DISP_DEPTH     = 2;

  typedef logic [DISP_PLD_WIDTH-1:0] disp_pld_t;
  typedef logic [$clog2(DISP_N)-1:0] disp_idx_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int disp_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/two_to_n_dispatch_dual_push_fifo.sv
// dual_push_fifo: DEPTH-entry FIFO with two ordered write ports (port 0 lands
// first) and one read port. The occupancy count is exported so the dispatcher
// can make its acceptance decision from registered state only.
module dual_push_fifo
  import vc_dispatch_pkg::*;
#(
  parameter  int W     = DISP_PLD_WIDTH,
  parameter  int DEPTH = DISP_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = disp_cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push0_i,
  input  logic [W-1:0]  data0_i,
  input  logic          push1_i,
  input  logic [W-1:0]  data1_i,
  input  logic          pop_i,
  output logic [CW-1:0] cnt_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr1;

  // Next-state pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr1  = wr_ptr_q + PW'(push0_i);
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    cnt_d    = cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  // Storage and pointer registers; reset discards every entry at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push0_i) begin
        mem_q[wr_ptr_q] <= data0_i;
      end
      if (push1_i) begin
        mem_q[wr_ptr1] <= data1_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

  // The dispatcher must never push past DEPTH nor pop an empty FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (int'(cnt_q) + int'(push0_i) + int'(push1_i)) <= (DEPTH + int'(pop_i)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/two_to_n_dispatch.sv
// two_to_n_dispatch: routes beats from two response lanes to N destination
// ports, each backed by its own dual_push_fifo so one stalled destination never
// blocks the others. Lane 0 has fixed priority on a shared destination.
// Optional macro TWO_TO_N_DISPATCH_DEST_CHK_EN: out-of-range destinations are
// accepted and dropped, raising a sticky dest_err_o; without it they stall.
module two_to_n_dispatch
  import vc_dispatch_pkg::*;
#(
  parameter  int N         = DISP_N,
  parameter  int PLD_WIDTH = DISP_PLD_WIDTH,
  parameter  int DEPTH     = DISP_DEPTH,
  localparam int IDX_W     = $clog2(N),
  localparam int CW        = disp_cnt_width(DEPTH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [DISP_LANES-1:0]                 in_vld_i,
  output logic [DISP_LANES-1:0]                 in_rdy_o,
  input  logic [DISP_LANES-1:0][IDX_W-1:0]      in_dest_i,
  input  logic [DISP_LANES-1:0][PLD_WIDTH-1:0]  in_pld_i,
  output logic [N-1:0]                          out_vld_o,
  input  logic [N-1:0]                          out_rdy_i,
  output logic [N-1:0][PLD_WIDTH-1:0]           out_pld_o,
  output logic                                  dest_err_o
);

  localparam logic [IDX_W:0]  NUM_PORTS = (IDX_W + 1)'(N);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);

  logic [CW-1:0]         cnt [N];
  logic [N-1:0]          push0, push1, pop;
  logic [DISP_LANES-1:0] in_range;
  logic [CW-1:0]         sel_cnt [DISP_LANES];
  logic [DISP_LANES-1:0] rdy, take;
  logic                  same_dest;
  logic [CW-1:0]         free1, need1;

  // Decode each lane: is the index a real port, and how full is that port's FIFO.
  // An unknown index reads as full so it can never be accepted into a FIFO.
  always_comb begin
    for (int l = 0; l < DISP_LANES; l++) begin
      in_range[l] = ({1'b0, in_dest_i[l]} < NUM_PORTS);
      sel_cnt[l]  = DEPTH_C;
      for (int i = 0; i < N; i++) begin
        if (in_dest_i[l] == IDX_W'(i)) begin
          sel_cnt[l] = cnt[i];
        end
      end
    end
  end

  // Acceptance from registered occupancy only; lane 1 reserves a second slot
  // when lane 0 is writing the same FIFO this cycle.
  always_comb begin
    same_dest = (in_dest_i[0] == in_dest_i[1]);
    rdy[0]    = in_range[0] && (sel_cnt[0] < DEPTH_C);
    take[0]   = in_vld_i[0] && rdy[0];
    free1     = DEPTH_C - sel_cnt[1];
    need1     = CW'(1) + CW'(take[0] && same_dest);
    rdy[1]    = in_range[1] && (free1 >= need1);
    take[1]   = in_vld_i[1] && rdy[1];
  end

  // Per-port push enables; both lanes share the data buses, order fixed by port number.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      push0[i] = take[0] && (in_dest_i[0] == IDX_W'(i));
      push1[i] = take[1] && (in_dest_i[1] == IDX_W'(i));
    end
  end

`ifdef TWO_TO_N_DISPATCH_DEST_CHK_EN
  logic dest_err_q, dest_err_d;

  assign in_rdy_o = (rdy | ~in_range) & {DISP_LANES{~rst_i}};

  // A dropped out-of-range beat latches the error flag until the next reset.
  always_comb begin
    dest_err_d = dest_err_q | (|(in_vld_i & in_rdy_o & ~in_range));
  end

  // Sticky error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dest_err_q <= 1'b0;
    end else begin
      dest_err_q <= dest_err_d;
    end
  end

  assign dest_err_o = dest_err_q;
`else
  assign in_rdy_o   = rdy & {DISP_LANES{~rst_i}};
  assign dest_err_o = 1'b0;
`endif

  for (genvar g = 0; g < N; g++) begin : g_port
    dual_push_fifo #(
      .W     (PLD_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push0_i (push0[g]),
      .data0_i (in_pld_i[0]),
      .push1_i (push1[g]),
      .data1_i (in_pld_i[1]),
      .pop_i   (pop[g]),
      .cnt_o   (cnt[g]),
      .head_o  (out_pld_o[g])
    );

    assign out_vld_o[g] = (cnt[g] != '0);
    assign pop[g]       = out_vld_o[g] & out_rdy_i[g];
  end

endmodule

// File: tb/tb_two_to_n_dispatch.sv
// tb_two_to_n_dispatch: directed scenarios with hand-computed expectations plus
// a short randomised run against a per-port queue model.
module tb_two_to_n_dispatch;

  localparam int N     = 10;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       inVld, inRdy;
  logic [1:0][3:0]  inDest;
  logic [1:0][7:0]  inPld;
  logic [N-1:0]     outVld, outRdy;
  logic [N-1:0][7:0] outPld;
  logic             destErr;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] expQ [N][$];

  always #5 clk = ~clk;

  two_to_n_dispatch #(.N(N), .PLD_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_vld_i   (inVld),
    .in_rdy_o   (inRdy),
    .in_dest_i  (inDest),
    .in_pld_i   (inPld),
    .out_vld_o  (outVld),
    .out_rdy_i  (outRdy),
    .out_pld_o  (outPld),
    .dest_err_o (destErr)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values, then a mid-traffic reset with FIFO 3 full.
  task automatic test_reset();
    rst = 1'b1; inVld = '0; inDest = '0; inPld = '0; outRdy = '1;
    tick(); tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_vld: got %b expected 0", outVld); end
    nCompared++; if (inRdy !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_in_rdy: got %b expected 00", inRdy); end
    nCompared++; if (outPld !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_pld: got %h expected 0", outPld); end
    nCompared++; if (destErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dest_err: got %b expected 0", destErr); end
    rst = 1'b0;
    outRdy[3] = 1'b0; inVld = 2'b01; inDest[0] = 4'd3; inPld[0] = 8'h31;
    #1;
    nCompared++; if (inRdy[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_load_rdy: got %b expected 1", inRdy[0]); end
    tick();
    inPld[0] = 8'h32;
    tick();
    inVld = 2'b00;
    #1;
    nCompared++; if (outVld !== 10'b0000001000) begin nMismatched++; $display("[TB] FAIL reset_loaded_vld: got %b expected 0000001000", outVld); end
    nCompared++; if (outPld[3] !== 8'h31) begin nMismatched++; $display("[TB] FAIL reset_loaded_head: got %h expected 31", outPld[3]); end
    nCompared++; if (inRdy[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_full_rdy: got %b expected 0", inRdy[0]); end
    inVld = 2'b01; rst = 1'b1;
    #1;
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL reset_mid_vld: got %b expected 0", outVld); end
    nCompared++; if (inRdy !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_mid_rdy: got %b expected 00", inRdy); end
    nCompared++; if (outPld[3] !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_mid_pld: got %h expected 00", outPld[3]); end
    tick();
    inVld = 2'b00; rst = 1'b0; outRdy = '1;
    #1;
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL reset_after_vld: got %b expected 0", outVld); end
    nCompared++; if (inRdy[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_after_rdy: got %b expected 1", inRdy[0]); end
    inVld = 2'b01; inPld[0] = 8'h3C;
    tick();
    inVld = 2'b00;
    nCompared++; if (outVld !== 10'b0000001000) begin nMismatched++; $display("[TB] FAIL reset_relaunch_vld: got %b expected 0000001000", outVld); end
    nCompared++; if (outPld[3] !== 8'h3C) begin nMismatched++; $display("[TB] FAIL reset_relaunch_pld: got %h expected 3c", outPld[3]); end
    tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL reset_relaunch_drain: got %b expected 0", outVld); end
  endtask

  // Both lanes to different ports in the same cycle.
  task automatic test_parallel();
    inVld = 2'b11; inDest[0] = 4'd1; inPld[0] = 8'hA1; inDest[1] = 4'd7; inPld[1] = 8'hB7;
    #1;
    nCompared++; if (inRdy !== 2'b11) begin nMismatched++; $display("[TB] FAIL parallel_rdy: got %b expected 11", inRdy); end
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL parallel_no_bypass: got %b expected 0", outVld); end
    tick();
    inVld = 2'b00;
    nCompared++; if (outVld !== 10'b0010000010) begin nMismatched++; $display("[TB] FAIL parallel_vld: got %b expected 0010000010", outVld); end
    nCompared++; if (outPld[1] !== 8'hA1) begin nMismatched++; $display("[TB] FAIL parallel_pld1: got %h expected a1", outPld[1]); end
    nCompared++; if (outPld[7] !== 8'hB7) begin nMismatched++; $display("[TB] FAIL parallel_pld7: got %h expected b7", outPld[7]); end
    tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL parallel_drain: got %b expected 0", outVld); end
  endtask

  // Both lanes to the same port: ordering, and the two-slot rule for lane 1.
  task automatic test_collision();
    outRdy[4] = 1'b0;
    inVld = 2'b11; inDest[0] = 4'd4; inPld[0] = 8'hA4; inDest[1] = 4'd4; inPld[1] = 8'hB4;
    #1;
    nCompared++; if (inRdy !== 2'b11) begin nMismatched++; $display("[TB] FAIL collision_empty_rdy: got %b expected 11", inRdy); end
    tick();
    inVld = 2'b00;
    nCompared++; if (outPld[4] !== 8'hA4) begin nMismatched++; $display("[TB] FAIL collision_first: got %h expected a4", outPld[4]); end
    outRdy[4] = 1'b1;
    tick();
    outRdy[4] = 1'b0;
    nCompared++; if (outPld[4] !== 8'hB4 || outVld[4] !== 1'b1) begin nMismatched++; $display("[TB] FAIL collision_second: got %h/%b expected b4/1", outPld[4], outVld[4]); end
    inVld = 2'b10; inPld[0] = 8'hC4; inPld[1] = 8'hD4;
    #1;
    nCompared++; if (inRdy !== 2'b11) begin nMismatched++; $display("[TB] FAIL collision_lane1_alone: got %b expected 11", inRdy); end
    inVld = 2'b11;
    #1;
    nCompared++; if (inRdy !== 2'b01) begin nMismatched++; $display("[TB] FAIL collision_one_free: got %b expected 01", inRdy); end
    tick();
    inVld = 2'b00;
    nCompared++; if (inRdy[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL collision_full: got %b expected 0", inRdy[0]); end
    outRdy[4] = 1'b1;
    tick();
    nCompared++; if (outPld[4] !== 8'hC4) begin nMismatched++; $display("[TB] FAIL collision_third: got %h expected c4", outPld[4]); end
    tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL collision_drain: got %b expected 0", outVld); end
  endtask

  // A stalled port fills up without blocking a different port.
  task automatic test_back_pressure();
    outRdy[2] = 1'b0;
    inVld = 2'b01; inDest[0] = 4'd2; inPld[0] = 8'h21;
    #1;
    nCompared++; if (inRdy[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_first_rdy: got %b expected 1", inRdy[0]); end
    tick();
    inPld[0] = 8'h22;
    nCompared++; if (inRdy[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_second_rdy: got %b expected 1", inRdy[0]); end
    tick();
    inVld = 2'b10; inDest[1] = 4'd5; inPld[1] = 8'h55;
    #1;
    nCompared++; if (inRdy !== 2'b10) begin nMismatched++; $display("[TB] FAIL bp_other_port: got %b expected 10", inRdy); end
    tick();
    inVld = 2'b00;
    nCompared++; if (outVld !== 10'b0000100100) begin nMismatched++; $display("[TB] FAIL bp_vld: got %b expected 0000100100", outVld); end
    nCompared++; if (outPld[5] !== 8'h55) begin nMismatched++; $display("[TB] FAIL bp_pld5: got %h expected 55", outPld[5]); end
    outRdy[2] = 1'b1;
    #1;
    nCompared++; if (inRdy[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_no_same_cycle_free: got %b expected 0", inRdy[0]); end
    tick();
    nCompared++; if (outPld[2] !== 8'h22) begin nMismatched++; $display("[TB] FAIL bp_order: got %h expected 22", outPld[2]); end
    nCompared++; if (inRdy[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_recover: got %b expected 1", inRdy[0]); end
    nCompared++; if (outVld !== 10'b0000000100) begin nMismatched++; $display("[TB] FAIL bp_after_pop_vld: got %b expected 0000000100", outVld); end
    tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL bp_drain: got %b expected 0", outVld); end
  endtask

  // Random traffic against per-port queues; final cycles drain everything.
  task automatic test_soak();
    logic [1:0]   expRdy;
    logic [N-1:0] expVld;
    bit           sameTake;
    bit           drain;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      drain = (cyc >= 1960);
      inVld = drain ? 2'b00 : 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++) begin
        inDest[l] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(3, 5)) : 4'($urandom_range(0, N - 1));
        inPld[l]  = 8'($urandom);
      end
      outRdy = drain ? '1 : N'($urandom);
      #1;
      expRdy[0] = (expQ[inDest[0]].size() < DEPTH);
      sameTake  = inVld[0] && expRdy[0] && (inDest[0] == inDest[1]);
      expRdy[1] = ((DEPTH - expQ[inDest[1]].size()) >= (1 + int'(sameTake)));
      for (int i = 0; i < N; i++) begin
        expVld[i] = (expQ[i].size() != 0);
      end
      nCompared++; if (inRdy !== expRdy) begin nMismatched++; $display("[TB] FAIL soak_rdy cyc %0d: got %b expected %b", cyc, inRdy, expRdy); end
      nCompared++; if (outVld !== expVld) begin nMismatched++; $display("[TB] FAIL soak_vld cyc %0d: got %b expected %b", cyc, outVld, expVld); end
      for (int i = 0; i < N; i++) begin
        if (expVld[i] && outRdy[i]) begin
          nCompared++;
          if (outPld[i] !== expQ[i][0]) begin nMismatched++; $display("[TB] FAIL soak_pld port %0d cyc %0d: got %h expected %h", i, cyc, outPld[i], expQ[i][0]); end
          void'(expQ[i].pop_front());
        end
      end
      if (inVld[0] && expRdy[0]) expQ[inDest[0]].push_back(inPld[0]);
      if (inVld[1] && expRdy[1]) expQ[inDest[1]].push_back(inPld[1]);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      nCompared++; if (expQ[i].size() != 0) begin nMismatched++; $display("[TB] FAIL soak_leftover port %0d: got %0d entries expected 0", i, expQ[i].size()); end
    end
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL soak_final_vld: got %b expected 0", outVld); end
  endtask

  // Lane 1 addressing a port that does not exist.
  task automatic test_dest_range();
    inVld = 2'b10; inDest[0] = 4'd0; inDest[1] = 4'd12; inPld[1] = 8'hEE; outRdy = '1;
    #1;
    nCompared++; if (destErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL range_err_before: got %b expected 0", destErr); end
`ifdef TWO_TO_N_DISPATCH_DEST_CHK_EN
    nCompared++; if (inRdy[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL range_rdy: got %b expected 1", inRdy[1]); end
    tick();
    inVld = 2'b00;
    #1;
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL range_dropped: got %b expected 0", outVld); end
    nCompared++; if (destErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL range_err_set: got %b expected 1", destErr); end
    tick(); tick();
    nCompared++; if (destErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL range_err_sticky: got %b expected 1", destErr); end
`else
    nCompared++; if (inRdy[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL range_stall: got %b expected 0", inRdy[1]); end
    tick(); tick();
    nCompared++; if (outVld !== '0) begin nMismatched++; $display("[TB] FAIL range_no_write: got %b expected 0", outVld); end
    nCompared++; if (inRdy[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL range_still_stalled: got %b expected 0", inRdy[1]); end
    nCompared++; if (destErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL range_err_tied: got %b expected 0", destErr); end
    inVld = 2'b00;
`endif
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_parallel();
    test_collision();
    test_back_pressure();
    test_soak();
    test_dest_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
